// File: rtl/rs_alloc_ctrl.sv
// Reservation-station occupancy controller: tracks busy entries and hands free entries
// to dispatch slots, lowest index first and strictly in slot order.
module rs_alloc_ctrl #(
  parameter int unsigned RS_DEPTH       = 64,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned CNT_W          = $clog2(RS_DEPTH + 1),
  parameter int unsigned CAP_W          = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [DISPATCH_WIDTH-1:0]                disp_valid_vec,
  output logic [DISPATCH_WIDTH-1:0][RS_DEPTH-1:0]  disp_grant_vec,
  output logic [DISPATCH_WIDTH-1:0]                disp_accept_vec,
  input  logic [RS_DEPTH-1:0]                      issue_release_vec,
  output logic [RS_DEPTH-1:0]                      busy_vec,
  output logic [CNT_W-1:0]                         free_count,
  output logic [CAP_W-1:0]                         free_slots,
  output logic                                     full
);

  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    free_q, free_d;
  logic [RS_DEPTH-1:0] grant_any;
  logic [CNT_W-1:0]    acc_cnt, rel_cnt;

  // A slot that finds no free entry blocks every higher slot for the rest of the cycle.
  always_comb begin : slot_scan
    logic [RS_DEPTH-1:0] mask;
    logic                blocked;
    logic                found;
    mask            = busy_q;
    blocked         = flush;
    found           = 1'b0;
    disp_grant_vec  = '0;
    disp_accept_vec = '0;
    grant_any       = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      found = 1'b0;
      if (disp_valid_vec[i] && !blocked) begin
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (!found && !mask[j]) begin
            disp_grant_vec[i][j] = 1'b1;
            found                = 1'b1;
          end
        end
        if (found) begin
          disp_accept_vec[i] = 1'b1;
          mask               = mask | disp_grant_vec[i];
          grant_any          = grant_any | disp_grant_vec[i];
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  always_comb begin
    acc_cnt = '0;
    rel_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      acc_cnt = acc_cnt + CNT_W'(disp_accept_vec[i]);
    end
    // Releases of idle entries are ignored, so only busy ones add back to the count.
    for (int j = 0; j < RS_DEPTH; j++) begin
      rel_cnt = rel_cnt + CNT_W'(issue_release_vec[j] & busy_q[j]);
    end
  end

  always_comb begin
    if (flush) begin
      busy_d = '0;
      free_d = CNT_W'(RS_DEPTH);
    end else begin
      busy_d = (busy_q | grant_any) & ~issue_release_vec;
      free_d = free_q - acc_cnt + rel_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      free_q <= CNT_W'(RS_DEPTH);
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
    end
  end

  assign busy_vec   = busy_q;
  assign free_count = free_q;
  assign free_slots = (free_q < CNT_W'(DISPATCH_WIDTH)) ? CAP_W'(free_q)
                                                        : CAP_W'(DISPATCH_WIDTH);
  assign full       = (free_q == '0);

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Self-checking bench for rs_alloc_ctrl: directed scenarios plus randomized traffic
// compared every cycle against an entry-list reference model.
module tb_rs_alloc_ctrl;
  localparam int unsigned D = 8;
  localparam int unsigned W = 2;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned PW = $clog2(W + 1);

  logic              clock = 1'b0;
  logic              reset, flush;
  logic [W-1:0]      disp_valid_vec;
  logic [W-1:0][D-1:0] disp_grant_vec;
  logic [W-1:0]      disp_accept_vec;
  logic [D-1:0]      issue_release_vec;
  logic [D-1:0]      busy_vec;
  logic [CW-1:0]     free_count;
  logic [PW-1:0]     free_slots;
  logic              full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: occupancy per entry as a plain bit array.
  bit                m_busy [D];
  logic [W-1:0]      last_acc;
  logic [D-1:0]      last_g0, last_g1;

  rs_alloc_ctrl #(.RS_DEPTH(D), .DISPATCH_WIDTH(W)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .disp_valid_vec    (disp_valid_vec),
    .disp_grant_vec    (disp_grant_vec),
    .disp_accept_vec   (disp_accept_vec),
    .issue_release_vec (issue_release_vec),
    .busy_vec          (busy_vec),
    .free_count        (free_count),
    .free_slots        (free_slots),
    .full              (full)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_free();
    int n = 0;
    for (int j = 0; j < D; j++) if (!m_busy[j]) n++;
    return n;
  endfunction

  function automatic logic [D-1:0] model_busy_vec();
    logic [D-1:0] v = '0;
    for (int j = 0; j < D; j++) v[j] = m_busy[j];
    return v;
  endfunction

  // Expected slot grants as entry indices (-1 = not accepted).
  function automatic void model_alloc(input logic [W-1:0] v, input logic fl,
                                      output int idx [W]);
    bit taken [D];
    bit stop = fl;
    for (int j = 0; j < D; j++) taken[j] = m_busy[j];
    for (int i = 0; i < W; i++) begin
      idx[i] = -1;
      if (v[i] && !stop) begin
        for (int j = D - 1; j >= 0; j--) if (!taken[j]) idx[i] = j;
        if (idx[i] >= 0) taken[idx[i]] = 1'b1;
        else stop = 1'b1;
      end
    end
  endfunction

  // Assumes entry at posedge+1; returns at the next posedge+1.
  task automatic step(input logic rst, input logic fl, input logic [W-1:0] v,
                      input logic [D-1:0] rel);
    int           idx [W];
    logic [D-1:0] exp_g;
    int           mf;
    reset = rst; flush = fl; disp_valid_vec = v; issue_release_vec = rel;
    @(negedge clock);
    model_alloc(v, fl, idx);
    mf = model_free();
    for (int i = 0; i < W; i++) begin
      exp_g = '0;
      if (idx[i] >= 0) exp_g[idx[i]] = 1'b1;
      check($sformatf("grant[%0d]", i), 32'(disp_grant_vec[i]), 32'(exp_g));
      check($sformatf("accept[%0d]", i), 32'(disp_accept_vec[i]), 32'(idx[i] >= 0));
    end
    check("busy_vec", 32'(busy_vec), 32'(model_busy_vec()));
    check("free_count", 32'(free_count), mf);
    check("free_slots", 32'(free_slots), (mf < W) ? mf : W);
    check("full", 32'(full), 32'(mf == 0));
    check("invariant", 32'(free_count), D - $countones(busy_vec));
    last_acc = disp_accept_vec;
    last_g0  = disp_grant_vec[0];
    last_g1  = disp_grant_vec[1];
    @(posedge clock);
    if (rst || fl) begin
      for (int j = 0; j < D; j++) m_busy[j] = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) if (idx[i] >= 0) m_busy[idx[i]] = 1'b1;
      for (int j = 0; j < D; j++) if (rel[j]) m_busy[j] = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [D-1:0] rel;
    logic         fl, rst;
    for (int j = 0; j < D; j++) m_busy[j] = 1'b0;
    reset = 1'b1; flush = 1'b0; disp_valid_vec = '0; issue_release_vec = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;

    // Fresh state, both slots dispatch.
    step(1'b0, 1'b0, 2'b11, 8'h00);
    check("lit_reset_acc", 32'(last_acc), 32'h3);
    check("lit_reset_g0", 32'(last_g0), 32'h01);
    check("lit_reset_g1", 32'(last_g1), 32'h02);
    check("lit_reset_busy", 32'(busy_vec), 32'h03);
    check("lit_reset_free", 32'(free_count), 6);

    // Fill up, then open entry 0 only.
    repeat (3) step(1'b0, 1'b0, 2'b11, 8'h00);
    check("lit_fill_busy", 32'(busy_vec), 32'hFF);
    step(1'b0, 1'b0, 2'b00, 8'h01);
    check("lit_fe_busy", 32'(busy_vec), 32'hFE);
    step(1'b0, 1'b0, 2'b11, 8'h00);
    check("lit_fe_acc", 32'(last_acc), 32'h1);
    check("lit_fe_g1", 32'(last_g1), 32'h00);
    check("lit_full", 32'(full), 1);
    check("lit_full_slots", 32'(free_slots), 0);

    // Release while full: takes effect the next cycle.
    step(1'b0, 1'b0, 2'b01, 8'h10);
    check("lit_relfull_acc", 32'(last_acc), 32'h0);
    check("lit_relfull_busy", 32'(busy_vec), 32'hEF);
    check("lit_relfull_free", 32'(free_count), 1);
    step(1'b0, 1'b0, 2'b01, 8'h00);
    check("lit_reuse_g0", 32'(last_g0), 32'h10);

    // Slot 1 only, with entry 0 busy.
    step(1'b0, 1'b1, 2'b00, 8'h00);
    step(1'b0, 1'b0, 2'b01, 8'h00);
    step(1'b0, 1'b0, 2'b10, 8'h00);
    check("lit_s1_acc", 32'(last_acc), 32'h2);
    check("lit_s1_g0", 32'(last_g0), 32'h00);
    check("lit_s1_g1", 32'(last_g1), 32'h02);

    // Build 8'h5A, then flush with dispatch and release in flight.
    step(1'b0, 1'b1, 2'b00, 8'h00);
    repeat (4) step(1'b0, 1'b0, 2'b11, 8'h00);
    step(1'b0, 1'b0, 2'b00, 8'hA5);
    check("lit_5a_busy", 32'(busy_vec), 32'h5A);
    step(1'b0, 1'b1, 2'b11, 8'h02);
    check("lit_flush_acc", 32'(last_acc), 32'h0);
    check("lit_flush_busy", 32'(busy_vec), 32'h00);
    check("lit_flush_free", 32'(free_count), 8);
    step(1'b0, 1'b0, 2'b11, 8'h00);
    step(1'b1, 1'b1, 2'b11, 8'h00);
    check("lit_rstflush_busy", 32'(busy_vec), 32'h00);
    check("lit_rstflush_free", 32'(free_count), 8);

    // Release of an idle entry is ignored.
    step(1'b0, 1'b0, 2'b01, 8'h00);
    step(1'b0, 1'b0, 2'b00, 8'h04);
    check("lit_idle_rel_busy", 32'(busy_vec), 32'h01);
    check("lit_idle_rel_free", 32'(free_count), 7);

    // Randomized traffic; releases target busy entries unless nothing dispatches.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      v   = W'($urandom);
      rel = D'($urandom) & D'($urandom) & model_busy_vec();
      if (v == '0) rel = rel | D'($urandom);
      step(rst, fl, v, rel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
